// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared LC-3 definitions for the fetch/decode sequencer: controller state
// encoding, opcode constants and PC source select encodings.
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH1  = 4'd1,
        ST_FETCH2  = 4'd2,
        ST_FETCH3  = 4'd3,
        ST_DECODE  = 4'd4,
        ST_BR      = 4'd5,
        ST_JMP     = 4'd6,
        ST_JSR1    = 4'd7,
        ST_JSR2    = 4'd8,
        ST_EXEC    = 4'd9,
        ST_ILLEGAL = 4'd10
    } seq_state_t;

    // Opcodes the sequencer handles itself; everything else goes to EXEC.
    localparam logic [3:0] OP_BR       = 4'b0000;
    localparam logic [3:0] OP_JSR      = 4'b0100;
    localparam logic [3:0] OP_JMP      = 4'b1100;
    localparam logic [3:0] OP_RSVD_DEF = 4'b1101;

    // PC source select.
    localparam logic [1:0] PCSEL_INC  = 2'd0;
    localparam logic [1:0] PCSEL_ADDR = 2'd1;
    localparam logic [1:0] PCSEL_BUS  = 2'd2;

endpackage

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// LC-3 style instruction fetch/decode sequencer. Fetches an instruction via
// MAR/MDR/IR, decodes the opcode, handles BR/JMP/JSR control flow directly
// and hands every other legal opcode to an external execute unit. Counts
// retired instructions; traps on the reserved opcode until reset.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   run                 1 = keep fetching; 0 = stop at next instruction end
//   mem_ready           memory read data valid
//   ir_op, ir_nzp       IR[15:12], IR[11:9]
//   cc_nzp              current condition codes
//   exec_done           execute unit finished the dispatched instruction
//   ld_pc, pc_sel       PC load strobe and source (INC/ADDR/BUS)
//   gate_pc/mdr/sr1     bus drivers
//   ld_mar/mdr/ir/r7    register load strobes
//   mem_en              memory read request
//   exec_start          one-cycle dispatch pulse
//   busy, illegal       instruction in flight; illegal opcode trapped
//   retired             completed-instruction count (wraps)
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          RETIRE_W = 16,
    parameter logic [3:0]  OP_RSVD  = OP_RSVD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [3:0]          ir_op,
    input  logic [2:0]          ir_nzp,
    input  logic [2:0]          cc_nzp,
    input  logic                exec_done,
    output logic                ld_pc,
    output logic [1:0]          pc_sel,
    output logic                gate_pc,
    output logic                gate_mdr,
    output logic                gate_sr1,
    output logic                ld_mar,
    output logic                ld_mdr,
    output logic                ld_ir,
    output logic                ld_r7,
    output logic                mem_en,
    output logic                exec_start,
    output logic                busy,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    seq_state_t state, next_state;
    logic       dispatch;   // high during the first EXEC cycle only
    logic       instr_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            dispatch <= 1'b0;
            retired  <= '0;
        end else begin
            state    <= next_state;
            dispatch <= (state == ST_DECODE) && (next_state == ST_EXEC);
            if (instr_end) begin
                retired <= retired + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        instr_end  = 1'b0;
        ld_pc      = 1'b0;
        pc_sel     = PCSEL_INC;
        gate_pc    = 1'b0;
        gate_mdr   = 1'b0;
        gate_sr1   = 1'b0;
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        ld_ir      = 1'b0;
        ld_r7      = 1'b0;
        mem_en     = 1'b0;
        exec_start = 1'b0;
        illegal    = 1'b0;
        busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (run) begin
                    next_state = ST_FETCH1;
                end
            end
            ST_FETCH1: begin
                gate_pc    = 1'b1;
                ld_mar     = 1'b1;
                ld_pc      = 1'b1;
                pc_sel     = PCSEL_INC;
                next_state = ST_FETCH2;
            end
            ST_FETCH2: begin
                // Read request stays up until memory answers; no timeout.
                mem_en = 1'b1;
                if (mem_ready) begin
                    ld_mdr     = 1'b1;
                    next_state = ST_FETCH3;
                end
            end
            ST_FETCH3: begin
                gate_mdr   = 1'b1;
                ld_ir      = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Reserved opcode is checked first so an override that
                // collides with a control-flow opcode still traps.
                if (ir_op == OP_RSVD) begin
                    next_state = ST_ILLEGAL;
                end else if (ir_op == OP_BR) begin
                    next_state = ST_BR;
                end else if (ir_op == OP_JMP) begin
                    next_state = ST_JMP;
                end else if (ir_op == OP_JSR) begin
                    next_state = ST_JSR1;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_BR: begin
                if (|(ir_nzp & cc_nzp)) begin
                    ld_pc  = 1'b1;
                    pc_sel = PCSEL_ADDR;
                end
                instr_end = 1'b1;
            end
            ST_JMP: begin
                gate_sr1  = 1'b1;
                ld_pc     = 1'b1;
                pc_sel    = PCSEL_BUS;
                instr_end = 1'b1;
            end
            ST_JSR1: begin
                gate_pc    = 1'b1;
                ld_r7      = 1'b1;
                next_state = ST_JSR2;
            end
            ST_JSR2: begin
                ld_pc = 1'b1;
                if (ir_nzp[2]) begin
                    pc_sel = PCSEL_ADDR;
                end else begin
                    pc_sel   = PCSEL_BUS;
                    gate_sr1 = 1'b1;
                end
                instr_end = 1'b1;
            end
            ST_EXEC: begin
                // exec_done during the dispatch cycle belongs to nothing we
                // issued, so it is ignored.
                if (dispatch) begin
                    exec_start = 1'b1;
                end else if (exec_done) begin
                    instr_end = 1'b1;
                end
            end
            ST_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (instr_end) begin
            next_state = run ? ST_FETCH1 : ST_IDLE;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed plus randomized instruction streams for fetch_sequencer. Each
// instruction is expanded into its expected per-cycle strobe pattern from
// the fetch/decode/execute rules, and retired is tracked as a simple count.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int RW = 4;

    // Expected-vector bit positions:
    // {ld_pc, pc_sel[1:0], gate_pc, gate_mdr, gate_sr1, ld_mar, ld_mdr,
    //  ld_ir, ld_r7, mem_en, exec_start, busy, illegal}
    localparam logic [13:0] LDPC     = 14'h2000;
    localparam logic [13:0] SEL_BUS  = 14'h1000;
    localparam logic [13:0] SEL_ADDR = 14'h0800;
    localparam logic [13:0] GPC      = 14'h0400;
    localparam logic [13:0] GMDR     = 14'h0200;
    localparam logic [13:0] GSR1     = 14'h0100;
    localparam logic [13:0] LMAR     = 14'h0080;
    localparam logic [13:0] LMDR     = 14'h0040;
    localparam logic [13:0] LIR      = 14'h0020;
    localparam logic [13:0] LR7      = 14'h0010;
    localparam logic [13:0] MEN      = 14'h0008;
    localparam logic [13:0] XST      = 14'h0004;
    localparam logic [13:0] BUSY     = 14'h0002;
    localparam logic [13:0] ILL      = 14'h0001;
    localparam logic [13:0] NONE     = 14'h0000;

    logic          clk, rst, run, mem_ready, exec_done;
    logic [3:0]    ir_op;
    logic [2:0]    ir_nzp, cc_nzp;
    logic          ld_pc, gate_pc, gate_mdr, gate_sr1;
    logic [1:0]    pc_sel;
    logic          ld_mar, ld_mdr, ld_ir, ld_r7, mem_en, exec_start;
    logic          busy, illegal;
    logic [RW-1:0] retired;

    logic [RW-1:0] exp_ret;
    int            vectors;
    int            miscompares;

    fetch_sequencer #(.RETIRE_W(RW), .OP_RSVD(4'b1101)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready),
        .ir_op(ir_op), .ir_nzp(ir_nzp), .cc_nzp(cc_nzp),
        .exec_done(exec_done), .ld_pc(ld_pc), .pc_sel(pc_sel),
        .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_sr1(gate_sr1),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_r7(ld_r7),
        .mem_en(mem_en), .exec_start(exec_start), .busy(busy),
        .illegal(illegal), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [13:0] observed();
        return {ld_pc, pc_sel, gate_pc, gate_mdr, gate_sr1, ld_mar, ld_mdr,
                ld_ir, ld_r7, mem_en, exec_start, busy, illegal};
    endfunction

    task automatic compare(input logic [13:0] e, input string tag);
        logic [13:0] obs;
        obs = observed();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: strobes got %h want %h", tag, obs, e);
        end
        vectors++;
        assert (retired === exp_ret) else begin
            miscompares++;
            $error("FAIL %s_retired: got %0d want %0d", tag, retired, exp_ret);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input logic [13:0] e, input string tag);
        #1;
        compare(e, tag);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        exp_ret = '0;
        compare(NONE, tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected behaviour of one instruction starting at its FETCH1 cycle.
    // Leaves the DUT about to enter FETCH1 of the next instruction (unless
    // the opcode traps).
    task automatic do_instr(input logic [3:0] op, input logic [2:0] nzp,
                            input logic [2:0] cc, input int mlat,
                            input int elat, input logic r);
        ir_op = op; ir_nzp = nzp; cc_nzp = cc;
        mem_ready = 1'b0; exec_done = 1'b0;
        run = rbit(); step(LDPC | GPC | LMAR | BUSY, "fetch1");
        for (int i = 0; i < mlat; i++) begin
            run = rbit(); step(MEN | BUSY, "fetch2_wait");
        end
        mem_ready = 1'b1;
        run = rbit(); step(MEN | LMDR | BUSY, "fetch2_ready");
        mem_ready = 1'b0;
        run = rbit(); step(GMDR | LIR | BUSY, "fetch3");
        run = rbit(); step(BUSY, "decode");
        if (op == 4'b1101) begin
            for (int i = 0; i < 4; i++) begin
                run = rbit(); mem_ready = rbit(); exec_done = rbit();
                step(BUSY | ILL, "illegal_hold");
            end
            mem_ready = 1'b0; exec_done = 1'b0;
            return;
        end
        if (op == 4'b0000) begin
            run = r;
            step(((nzp & cc) != 3'b000) ? (LDPC | SEL_ADDR | BUSY) : BUSY, "br");
        end else if (op == 4'b1100) begin
            run = r; step(GSR1 | LDPC | SEL_BUS | BUSY, "jmp");
        end else if (op == 4'b0100) begin
            run = rbit(); step(GPC | LR7 | BUSY, "jsr1");
            run = r;
            step(nzp[2] ? (LDPC | SEL_ADDR | BUSY) : (LDPC | SEL_BUS | GSR1 | BUSY), "jsr2");
        end else begin
            exec_done = rbit(); run = rbit(); step(XST | BUSY, "exec_start");
            exec_done = 1'b0;
            for (int i = 0; i < elat; i++) begin
                run = rbit(); step(BUSY, "exec_wait");
            end
            exec_done = 1'b1; run = r; step(BUSY, "exec_done");
            exec_done = 1'b0;
        end
        exp_ret = exp_ret + {{(RW-1){1'b0}}, 1'b1};
        if (!r) begin
            run = 1'b0; step(NONE, "idle_stop");
            run = 1'b1; step(NONE, "idle_go");
        end
    endtask

    task automatic rand_instr();
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'b1101) op = 4'b0001;
        do_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) != 0));
    endtask

    initial begin
        vectors = 0; miscompares = 0; exp_ret = '0;
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
        ir_op = 4'h0; ir_nzp = 3'b000; cc_nzp = 3'b000;

        // Reset state and idle behaviour.
        repeat (2) @(negedge clk);
        step(NONE, "in_reset");
        rst = 1'b0;
        step(NONE, "idle_hold0");
        step(NONE, "idle_hold1");
        run = 1'b1; step(NONE, "idle_go");

        // Basic ADD-like instruction through the execute unit.
        do_instr(4'b0001, 3'b000, 3'b000, 1, 1, 1'b1);
        // Branches: taken, not taken, BRnzp=000 NOP.
        do_instr(4'b0000, 3'b010, 3'b010, 0, 0, 1'b1);
        do_instr(4'b0000, 3'b010, 3'b100, 0, 0, 1'b1);
        do_instr(4'b0000, 3'b000, 3'b111, 0, 0, 1'b1);
        // JMP, JSRR (register) and JSR (PC-relative).
        do_instr(4'b1100, 3'b000, 3'b000, 0, 0, 1'b1);
        do_instr(4'b0100, 3'b011, 3'b000, 0, 0, 1'b1);
        do_instr(4'b0100, 3'b100, 3'b000, 2, 0, 1'b1);
        // Long memory wait.
        do_instr(4'b0110, 3'b000, 3'b000, 5, 0, 1'b1);
        // run dropped during EXEC: completes, then IDLE.
        do_instr(4'b0101, 3'b000, 3'b000, 0, 3, 1'b0);

        // Exactly 2^RW retirements from reset wrap the counter to zero.
        reset_pulse("wrap_rst");
        run = 1'b1; step(NONE, "idle_go");
        for (int i = 0; i < (1 << RW); i++) begin
            rand_instr();
        end
        #1;
        vectors++;
        assert (retired === '0) else begin
            miscompares++;
            $error("FAIL wrap: retired got %0d want 0", retired);
        end
        @(negedge clk);
        // That check consumed a cycle; realign to a known state.
        reset_pulse("realign_rst");
        run = 1'b1; step(NONE, "idle_go");

        for (int i = 0; i < 24; i++) begin
            rand_instr();
        end

        // Reset while waiting for memory.
        ir_op = 4'b0001; mem_ready = 1'b0;
        run = 1'b1; step(LDPC | GPC | LMAR | BUSY, "f2rst_fetch1");
        for (int i = 0; i < 3; i++) begin
            step(MEN | BUSY, "f2rst_wait");
        end
        reset_pulse("f2rst");
        run = 1'b0; step(NONE, "f2rst_idle");
        run = 1'b1; step(NONE, "idle_go");

        // Illegal opcode traps until reset, then normal operation resumes.
        do_instr(4'b1101, 3'b000, 3'b000, 1, 0, 1'b1);
        reset_pulse("illegal_rst");
        run = 1'b1; step(NONE, "idle_go");
        do_instr(4'b0000, 3'b001, 3'b001, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
